// File: rtl/seq_normalizer.sv
// Sequential normalizer: shifts an operand one bit per cycle until its leading bit is set, reporting the shift count.
// Optional macro SEQ_NORMALIZER_RIGHT_EN adds a dir port selecting right normalization (trailing zeros).
module seq_normalizer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_NORMALIZER_RIGHT_EN
    input  logic             dir,
`endif
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic             lead_bit;
    logic [WIDTH-1:0] shifted;
    logic             accept;

`ifdef SEQ_NORMALIZER_RIGHT_EN
    logic dir_q;

    // dir_q picks which end is tested and which way the operand moves
    always_comb begin
        lead_bit = data_out[WIDTH-1];
        shifted  = data_out << 1;
        if (dir_q) begin
            lead_bit = data_out[0];
            shifted  = data_out >> 1;
        end
    end
`else
    always_comb begin
        lead_bit = data_out[WIDTH-1];
        shifted  = data_out << 1;
    end
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));

    // data_out doubles as the working register; it holds the result once shifting stops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            shift_cnt <= '0;
            zero      <= 1'b0;
`ifdef SEQ_NORMALIZER_RIGHT_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        data_out  <= data_in;
                        shift_cnt <= '0;
                        zero      <= (data_in == '0);
`ifdef SEQ_NORMALIZER_RIGHT_EN
                        dir_q     <= dir;
`endif
                        if (data_in == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (lead_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        data_out  <= shifted;
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed literal cases plus randomized traffic against a behavioural model.
module tb_seq_normalizer;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          dir;
    logic [W-1:0]  data_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  data_out;
    logic [CW-1:0] shift_cnt;
    logic          zero;

    int tests;
    int fails;

    seq_normalizer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SEQ_NORMALIZER_RIGHT_EN
        .dir       (dir),
`endif
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .shift_cnt (shift_cnt),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of zeros before the first set bit, scanning from the MSB (dr=0) or LSB (dr=1)
    function automatic int unsigned lead_zeros(input logic [W-1:0] d, input logic dr);
        int unsigned k = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (dr ? d[i] : d[W-1-i]) break;
            k++;
        end
        return k;
    endfunction

    // Behavioural model: cycles of busy remaining, done flag, and visible results
    int unsigned   m_left;
    logic          m_done;
    logic [W-1:0]  e_out, p_out;
    logic [CW-1:0] e_cnt, p_cnt;
    logic          e_zero;
    int unsigned   mk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0;
            e_out = '0; e_cnt = '0; e_zero = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                if (data_in == '0) begin
                    m_done = 1'b1;
                    e_out = '0; e_cnt = '0; e_zero = 1'b1;
                end else begin
                    mk     = lead_zeros(data_in, dir);
                    m_left = mk + 1;
                    m_done = 1'b0;
                    p_out  = dir ? (data_in >> mk) : (data_in << mk);
                    p_cnt  = CW'(mk);
                end
            end else begin
                m_done = 1'b0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                e_out = p_out; e_cnt = p_cnt; e_zero = 1'b0;
            end
        end
    end

    logic cmp_en;
    initial cmp_en = 1'b0;

    // Per-cycle comparison against the model; results are only meaningful outside SHIFT
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("done", 32'(done), 32'(m_done));
            if (m_left == 0) begin
                chk("data_out", 32'(data_out), 32'(e_out));
                chk("shift_cnt", 32'(shift_cnt), 32'(e_cnt));
                chk("zero", 32'(zero), 32'(e_zero));
            end
        end
    end

    // One-cycle start pulse; returns edges from E0 to done and cycles busy was seen
    task automatic run(input logic [W-1:0] d, input logic dr, output int lat, output int bcnt);
        @(posedge clk); #1;
        start = 1'b1; data_in = d; dir = dr;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) chk("done_timeout", 32'(lat), 32'(0));
    endtask

    int lat, bcnt, seen;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; start = 1'b0; dir = 1'b0; data_in = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_out", 32'(data_out), 32'(0));
        chk("rst_cnt", 32'(shift_cnt), 32'(0));
        chk("rst_zero", 32'(zero), 32'(0));
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;

        run(8'b0001_0110, 1'b0, lat, bcnt);
        chk("k3_lat", 32'(lat), 32'(4));
        chk("k3_busy", 32'(bcnt), 32'(4));
        chk("k3_out", 32'(data_out), 32'(8'b1011_0000));
        chk("k3_cnt", 32'(shift_cnt), 32'(3));
        chk("k3_zero", 32'(zero), 32'(0));

        run(8'b1000_0000, 1'b0, lat, bcnt);
        chk("k0_lat", 32'(lat), 32'(1));
        chk("k0_out", 32'(data_out), 32'(8'b1000_0000));
        chk("k0_cnt", 32'(shift_cnt), 32'(0));

        run(8'b0000_0001, 1'b0, lat, bcnt);
        chk("k7_lat", 32'(lat), 32'(8));
        chk("k7_out", 32'(data_out), 32'(8'b1000_0000));
        chk("k7_cnt", 32'(shift_cnt), 32'(7));

        run(8'b0000_0000, 1'b0, lat, bcnt);
        chk("z_lat", 32'(lat), 32'(0));
        chk("z_busy", 32'(bcnt), 32'(0));
        chk("z_zero", 32'(zero), 32'(1));
        chk("z_out", 32'(data_out), 32'(0));
        chk("z_cnt", 32'(shift_cnt), 32'(0));

        // start during SHIFT is ignored
        @(posedge clk); #1 start = 1'b1; data_in = 8'b0000_0001;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; data_in = 8'b1111_1111;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        while (!done && seen < 40) begin @(posedge clk); #1; seen++; end
        chk("ign_cnt", 32'(shift_cnt), 32'(7));
        chk("ign_out", 32'(data_out), 32'(8'b1000_0000));

        // start held through DONE re-arms without an IDLE cycle
        @(posedge clk); #1 start = 1'b1; data_in = 8'b0100_0000;
        seen = 0;
        @(posedge clk); #1;
        while (!done && seen < 40) begin @(posedge clk); #1; seen++; end
        chk("held_done", 32'(done), 32'(1));
        @(posedge clk); #1;
        chk("held_rearm_busy", 32'(busy), 32'(1));
        chk("held_rearm_done", 32'(done), 32'(0));
        start = 1'b0;
        seen = 0;
        while (!done && seen < 40) begin @(posedge clk); #1; seen++; end
        chk("held_cnt", 32'(shift_cnt), 32'(1));

        // reset mid-operation
        @(posedge clk); #1 start = 1'b1; data_in = 8'b0000_0001;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_out", 32'(data_out), 32'(0));
        chk("mid_rst_cnt", 32'(shift_cnt), 32'(0));
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done) seen++; end
        chk("no_done_after_rst", 32'(seen), 32'(0));
        run(8'b0100_0000, 1'b0, lat, bcnt);
        chk("post_rst_cnt", 32'(shift_cnt), 32'(1));
        chk("post_rst_lat", 32'(lat), 32'(2));

`ifdef SEQ_NORMALIZER_RIGHT_EN
        run(8'b0110_1000, 1'b1, lat, bcnt);
        chk("r_lat", 32'(lat), 32'(4));
        chk("r_out", 32'(data_out), 32'(8'b0000_1101));
        chk("r_cnt", 32'(shift_cnt), 32'(3));
`endif

        // randomized traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start   = ($urandom % 100) < 35;
            data_in = W'($urandom) >> ($urandom % (W + 1));
`ifdef SEQ_NORMALIZER_RIGHT_EN
            dir     = 1'($urandom);
`endif
            if (($urandom % 300) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
